crc32_fcs_tx_ctrl: RTL



---
 rtl/crc32_fcs_tx_ctrl_pkg.sv | 35 +++
 rtl/crc32_fcs_tx_ctrl_byte_step.sv | 20 ++
 rtl/crc32_fcs_tx_ctrl.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/crc32_fcs_tx_ctrl_pkg.sv
// Shared constants, state encoding and bit-reflection helpers for the TX FCS sequencer.
package crc32_fcs_tx_ctrl_pkg;

    localparam int datalen = 8;
    localparam int crc_len = 32;
    localparam logic [crc_len-1:0] crc_poly = 32'h04C1_1DB7;
    localparam logic [crc_len-1:0] crc_init = 32'hFFFF_FFFF;
    localparam logic [10:0]        len_max  = 11'h7FF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        PAD  = 2'd2,
        FCS  = 2'd3
    } tx_fcs_state_e;

    function automatic logic [datalen-1:0] reflect8(input logic [datalen-1:0] d);
        logic [datalen-1:0] r;
        r = 8'h00;
        for (int i = 0; i < datalen; i++) begin
            r[i] = d[datalen-1-i];
        end
        return r;
    endfunction

    function automatic logic [crc_len-1:0] reflect32(input logic [crc_len-1:0] d);
        logic [crc_len-1:0] r;
        r = 32'h0000_0000;
        for (int i = 0; i < crc_len; i++) begin
            r[i] = d[crc_len-1-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/crc32_fcs_tx_ctrl_byte_step.sv
// One byte of MSB-first CRC-32; the byte is reflected so the register matches Ethernet bit order.
module crc32_byte_step
    import crc32_fcs_tx_ctrl_pkg::*;
(
    input  logic [crc_len-1:0] crc_in,
    input  logic [datalen-1:0] data_in,
    output logic [crc_len-1:0] crc_out
);

    // Eight shift/XOR steps over the reflected byte
    always_comb begin
        logic [crc_len-1:0] c_s;
        c_s = crc_in ^ {reflect8(data_in), 24'h00_0000};
        for (int i = 0; i < datalen; i++) begin
            c_s = c_s[crc_len-1] ? ((c_s << 1) ^ crc_poly) : (c_s << 1);
        end
        crc_out = c_s;
    end

endmodule

// File: rtl/crc32_fcs_tx_ctrl.sv
// TX FCS sequencer: forwards payload, zero-pads to MIN_LEN, then appends the 4-byte Ethernet FCS.
module crc32_fcs_tx_ctrl
    import crc32_fcs_tx_ctrl_pkg::*;
#(
    parameter int unsigned MIN_LEN = 60
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [datalen-1:0] s_data,
    input  logic               s_valid,
    input  logic               s_last,
    output logic               s_ready,
    output logic [datalen-1:0] m_data,
    output logic               m_valid,
    output logic               m_last,
    input  logic               m_ready,
    output logic               busy,
    output logic [10:0]        frame_len
);

    localparam logic [10:0] MIN_LEN_C = MIN_LEN[10:0];

    tx_fcs_state_e      state_r, state_nxt_s;
    logic [crc_len-1:0] crc_r, crc_nxt_s, crc_step_s, fcs_s;
    logic [datalen-1:0] m_data_r, m_data_nxt_s, step_in_s, fcs_byte_s;
    logic               m_valid_r, m_valid_nxt_s, m_last_r, m_last_nxt_s;
    logic [10:0]        cnt_r, cnt_nxt_s, cnt_inc_s, frame_len_r, frame_len_nxt_s;
    logic [11:0]        fl_sum_s;
    logic [1:0]         idx_r, idx_nxt_s;
    logic               adv_s, accept_s;

    assign adv_s     = !m_valid_r || m_ready;
    assign s_ready   = !rst && ((state_r == IDLE) || (state_r == DATA)) && adv_s;
    assign accept_s  = s_valid && s_ready;
    assign cnt_inc_s = (cnt_r == len_max) ? len_max : (cnt_r + 11'd1);
    assign fl_sum_s  = {1'b0, cnt_r} + 12'd4;
    assign step_in_s = (state_r == PAD) ? 8'h00 : s_data;
    assign fcs_s     = ~reflect32(crc_r);

    crc32_byte_step u_step (
        .crc_in  (crc_r),
        .data_in (step_in_s),
        .crc_out (crc_step_s)
    );

    // FCS goes out least-significant byte first
    always_comb begin
        case (idx_r)
            2'd0:    fcs_byte_s = fcs_s[7:0];
            2'd1:    fcs_byte_s = fcs_s[15:8];
            2'd2:    fcs_byte_s = fcs_s[23:16];
            2'd3:    fcs_byte_s = fcs_s[31:24];
            default: fcs_byte_s = 8'h00;
        endcase
    end

    // Next-state, output-register and counter logic
    always_comb begin
        state_nxt_s     = state_r;
        crc_nxt_s       = crc_r;
        m_data_nxt_s    = m_data_r;
        m_valid_nxt_s   = m_valid_r;
        m_last_nxt_s    = m_last_r;
        cnt_nxt_s       = cnt_r;
        idx_nxt_s       = idx_r;
        frame_len_nxt_s = frame_len_r;
        if (adv_s) begin
            m_valid_nxt_s = 1'b0;
            m_last_nxt_s  = 1'b0;
        end else begin
            m_valid_nxt_s = m_valid_r;
        end
        case (state_r)
            IDLE, DATA: begin
                if (accept_s) begin
                    m_data_nxt_s  = s_data;
                    m_valid_nxt_s = 1'b1;
                    crc_nxt_s     = crc_step_s;
                    cnt_nxt_s     = (state_r == IDLE) ? 11'd1 : cnt_inc_s;
                    if (s_last) begin
                        state_nxt_s = (cnt_nxt_s < MIN_LEN_C) ? PAD : FCS;
                    end else begin
                        state_nxt_s = DATA;
                    end
                end else begin
                    state_nxt_s = state_r;
                end
            end
            PAD: begin
                if (adv_s) begin
                    m_data_nxt_s  = 8'h00;
                    m_valid_nxt_s = 1'b1;
                    crc_nxt_s     = crc_step_s;
                    cnt_nxt_s     = cnt_inc_s;
                    state_nxt_s   = (cnt_inc_s >= MIN_LEN_C) ? FCS : PAD;
                end else begin
                    state_nxt_s = PAD;
                end
            end
            FCS: begin
                // crc stays frozen until the final FCS byte is loaded
                if (adv_s) begin
                    m_data_nxt_s  = fcs_byte_s;
                    m_valid_nxt_s = 1'b1;
                    m_last_nxt_s  = (idx_r == 2'd3);
                    idx_nxt_s     = idx_r + 2'd1;
                    if (idx_r == 2'd3) begin
                        frame_len_nxt_s = fl_sum_s[11] ? len_max : fl_sum_s[10:0];
                        crc_nxt_s       = crc_init;
                        state_nxt_s     = IDLE;
                    end else begin
                        state_nxt_s = FCS;
                    end
                end else begin
                    state_nxt_s = FCS;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            crc_r       <= crc_init;
            m_data_r    <= 8'h00;
            m_valid_r   <= 1'b0;
            m_last_r    <= 1'b0;
            cnt_r       <= 11'd0;
            idx_r       <= 2'd0;
            frame_len_r <= 11'd0;
        end else begin
            state_r     <= state_nxt_s;
            crc_r       <= crc_nxt_s;
            m_data_r    <= m_data_nxt_s;
            m_valid_r   <= m_valid_nxt_s;
            m_last_r    <= m_last_nxt_s;
            cnt_r       <= cnt_nxt_s;
            idx_r       <= idx_nxt_s;
            frame_len_r <= frame_len_nxt_s;
        end
    end

    assign m_data    = m_data_r;
    assign m_valid   = m_valid_r;
    assign m_last    = m_last_r;
    assign busy      = (state_r != IDLE);
    assign frame_len = frame_len_r;

endmodule
